// File: rtl/alu_op_issuer.sv
// Command front-end for the combinational 8-bit ALU: queues commands,
// drives the ALU input struct, samples its result after a settle time
// and returns tagged results in order.
//
// Ports:
//   clk, rst                    clock (rising edge), async active-high reset
//   cmd_valid/cmd_ready         command handshake (ready = FIFO not full)
//   cmd_a, cmd_b, cmd_op        operands and ALU control code
//   cmd_tag                     opaque tag returned with the result
//   alu_req                     {a_in, b_in, control_in} to the ALU
//   alu_rsp                     {result_out} from the ALU
//   rsp_valid/rsp_ready         response handshake
//   rsp_result, rsp_tag         captured result and its tag
//   rsp_dbz                     divide-by-zero flag
//   busy                        FSM not idle or FIFO not empty
//   ops_done                    count of completed response handshakes
module alu_op_issuer #(
    parameter int FIFO_DEPTH    = 4,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_a,
    input  logic [7:0]  cmd_b,
    input  logic [2:0]  cmd_op,
    input  logic [3:0]  cmd_tag,
    output logic [18:0] alu_req,
    input  logic [15:0] alu_rsp,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_result,
    output logic [3:0]  rsp_tag,
    output logic        rsp_dbz,
    output logic        busy,
    output logic [15:0] ops_done
);

    typedef struct packed {
        logic [7:0] a_in;
        logic [7:0] b_in;
        logic [2:0] control_in;
    } ip_port_t;

    typedef struct packed {
        logic [15:0] result_out;
    } op_port_t;

    typedef struct packed {
        ip_port_t   req;
        logic [3:0] tag;
    } entry_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_HOLD
    } state_t;

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE_CYCLES - 1);

    // FIFO storage; pointers carry one extra wrap bit to tell full from empty.
    entry_t        mem_q [FIFO_DEPTH];
    logic [AW:0]   wr_q;
    logic [AW:0]   rd_q;
    logic [AW:0]   wr_d;
    logic [AW:0]   rd_d;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    entry_t        head;
    entry_t        cmd_entry;

    state_t        state_q;
    ip_port_t      req_q;
    logic [3:0]    tag_q;
    logic [CW-1:0] cnt_q;
    logic          rsp_valid_q;
    logic [15:0]   rsp_result_q;
    logic [3:0]    rsp_tag_q;
    logic          rsp_dbz_q;
    logic [15:0]   ops_q;
    logic [15:0]   ops_d;
    op_port_t      rsp_s;
    logic          div_zero;

    assign empty     = (wr_q == rd_q);
    assign full      = (wr_q[AW] != rd_q[AW]) &&
                       (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign cmd_ready = !full;
    assign push      = cmd_valid && !full;
    // A pop happens from IDLE, or on the response handshake (back-to-back).
    assign pop       = !empty &&
                       ((state_q == S_IDLE) ||
                        (state_q == S_HOLD && rsp_ready));
    assign head      = mem_q[rd_q[AW-1:0]];
    assign wr_d      = wr_q + (AW+1)'(1);
    assign rd_d      = rd_q + (AW+1)'(1);
    assign ops_d     = ops_q + 16'd1;

    assign cmd_entry.req.a_in       = cmd_a;
    assign cmd_entry.req.b_in       = cmd_b;
    assign cmd_entry.req.control_in = cmd_op;
    assign cmd_entry.tag            = cmd_tag;

    assign rsp_s    = op_port_t'(alu_rsp);
    assign div_zero = (req_q.control_in == 3'b011) && (req_q.b_in == 8'd0);

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_q[AW-1:0]] <= cmd_entry;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (push) begin
                wr_q <= wr_d;
            end
            if (pop) begin
                rd_q <= rd_d;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            req_q        <= '0;
            tag_q        <= '0;
            cnt_q        <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_tag_q    <= '0;
            rsp_dbz_q    <= 1'b0;
            ops_q        <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        req_q   <= head.req;
                        tag_q   <= head.tag;
                        cnt_q   <= CNT_LOAD;
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CW'(1);
                    end else begin
                        // A zero divisor makes the ALU output meaningless.
                        rsp_result_q <= div_zero ? 16'hFFFF : rsp_s.result_out;
                        rsp_dbz_q    <= div_zero;
                        rsp_tag_q    <= tag_q;
                        rsp_valid_q  <= 1'b1;
                        state_q      <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        ops_q       <= ops_d;
                        if (pop) begin
                            req_q   <= head.req;
                            tag_q   <= head.tag;
                            cnt_q   <= CNT_LOAD;
                            state_q <= S_WAIT;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign alu_req    = req_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_tag    = rsp_tag_q;
    assign rsp_dbz    = rsp_dbz_q;
    assign ops_done   = ops_q;
    assign busy       = (state_q != S_IDLE) || !empty;

endmodule

// File: tb/tb_alu_op_issuer.sv
// Bench for alu_op_issuer: directed and randomized commands checked
// against an arithmetic reference model and an in-order expectation queue.
module tb_alu_op_issuer;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        c_valid, c_ready, r_valid, r_ready, r_dbz, busy;
    logic [7:0]  c_a, c_b;
    logic [2:0]  c_op;
    logic [3:0]  c_tag, r_tag;
    logic [18:0] a_req;
    logic [15:0] a_rsp, r_res, ops;

    logic        c3_valid, c3_ready, r3_valid, r3_ready, r3_dbz, busy3;
    logic [7:0]  c3_a, c3_b;
    logic [2:0]  c3_op;
    logic [3:0]  c3_tag, r3_tag;
    logic [18:0] a_req3;
    logic [15:0] a_rsp3, r3_res, ops3;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_ops  = 0;
    logic [20:0] exp_q[$];
    logic [15:0] last_res;
    logic        last_dbz;

    // Behavioural 8-bit ALU: 16-bit result context.
    function automatic logic [15:0] alu_model(input logic [18:0] req);
        logic [15:0] a, b;
        a = {8'h00, req[18:11]};
        b = {8'h00, req[10:3]};
        case (req[2:0])
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a * b;
            3'd3: return (b == 16'd0) ? 16'hDEAD : a / b;
            3'd4: return a | b;
            3'd5: return a ^ b;
            3'd6: return a & b;
            default: return ~a;
        endcase
    endfunction

    // Expected response {tag, dbz, result} for one command.
    function automatic logic [20:0] ref_rsp(input logic [7:0] a, b,
                                            input logic [2:0] op,
                                            input logic [3:0] tag);
        if (op == 3'd3 && b == 8'd0) return {tag, 1'b1, 16'hFFFF};
        return {tag, 1'b0, alu_model({a, b, op})};
    endfunction

    assign a_rsp  = alu_model(a_req);
    assign a_rsp3 = alu_model(a_req3);

    alu_op_issuer #(.FIFO_DEPTH(4), .SETTLE_CYCLES(1)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(c_valid), .cmd_ready(c_ready),
        .cmd_a(c_a), .cmd_b(c_b), .cmd_op(c_op), .cmd_tag(c_tag),
        .alu_req(a_req), .alu_rsp(a_rsp),
        .rsp_valid(r_valid), .rsp_ready(r_ready),
        .rsp_result(r_res), .rsp_tag(r_tag), .rsp_dbz(r_dbz),
        .busy(busy), .ops_done(ops)
    );

    alu_op_issuer #(.FIFO_DEPTH(4), .SETTLE_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst),
        .cmd_valid(c3_valid), .cmd_ready(c3_ready),
        .cmd_a(c3_a), .cmd_b(c3_b), .cmd_op(c3_op), .cmd_tag(c3_tag),
        .alu_req(a_req3), .alu_rsp(a_rsp3),
        .rsp_valid(r3_valid), .rsp_ready(r3_ready),
        .rsp_result(r3_res), .rsp_tag(r3_tag), .rsp_dbz(r3_dbz),
        .busy(busy3), .ops_done(ops3)
    );

    task automatic check(input string name, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] a, b, input logic [2:0] op,
                        input logic [3:0] tag);
        c_a = a; c_b = b; c_op = op; c_tag = tag; c_valid = 1'b1;
        check("cmd_ready", 32'(c_ready), 32'(1));
        tick();
        c_valid = 1'b0;
        exp_q.push_back(ref_rsp(a, b, op, tag));
    endtask

    task automatic take(input string name);
        logic [20:0] e;
        int n = 0;
        while (!r_valid && n < 50) begin
            tick();
            n++;
        end
        check({name, "_valid"}, 32'(r_valid), 32'(1));
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 21'h1FFFFF;
        check({name, "_res"}, 32'(r_res), 32'(e[15:0]));
        check({name, "_dbz"}, 32'(r_dbz), 32'(e[16]));
        check({name, "_tag"}, 32'(r_tag), 32'(e[20:17]));
        last_res = r_res;
        last_dbz = r_dbz;
        r_ready = 1'b1;
        tick();
        r_ready = 1'b0;
        exp_ops++;
        check({name, "_ops"}, 32'(ops), 32'(exp_ops));
    endtask

    initial begin
        logic [20:0] e;
        logic [18:0] req3;
        int got, last, cyc, sent, recvd, highs;
        logic acc, hs;

        c_valid = 0; c_a = 0; c_b = 0; c_op = 0; c_tag = 0; r_ready = 0;
        c3_valid = 0; c3_a = 0; c3_b = 0; c3_op = 0; c3_tag = 0;
        r3_ready = 0;

        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 32'(r_valid), 32'(0));
        check("rst_req", 32'(a_req), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_ops", 32'(ops), 32'(0));
        check("rst_res", 32'(r_res), 32'(0));
        check("rst_tag", 32'(r_tag), 32'(0));
        check("rst_dbz", 32'(r_dbz), 32'(0));
        rst = 1'b0;
        tick();
        check("rst_ready", 32'(c_ready), 32'(1));

        // Add with latency and hold-stability checks.
        send(8'd200, 8'd100, 3'd0, 4'd5);
        check("add_lat0", 32'(r_valid), 32'(0));
        tick();
        check("add_lat1", 32'(r_valid), 32'(0));
        tick();
        check("add_lat2", 32'(r_valid), 32'(1));
        check("add_res", 32'(r_res), 32'd300);
        check("add_tag", 32'(r_tag), 32'd5);
        check("add_dbz", 32'(r_dbz), 32'(0));
        for (int k = 0; k < 3; k++) begin
            tick();
            check("hold_valid", 32'(r_valid), 32'(1));
            check("hold_res", 32'(r_res), 32'd300);
            check("hold_tag", 32'(r_tag), 32'd5);
        end
        take("add");
        check("add_ops1", 32'(ops), 32'd1);
        check("add_drop", 32'(r_valid), 32'(0));

        // Directed arithmetic and divide cases.
        send(8'd255, 8'd255, 3'd2, 4'd1);
        take("mul");
        check("mul_k", 32'(last_res), 32'hFE01);
        send(8'd3, 8'd5, 3'd1, 4'd2);
        take("sub");
        check("sub_k", 32'(last_res), 32'hFFFE);
        send(8'h0F, 8'h00, 3'd7, 4'd3);
        take("not");
        check("not_k", 32'(last_res), 32'hFFF0);
        send(8'hA5, 8'h5A, 3'd5, 4'd4);
        take("xor");
        check("xor_k", 32'(last_res), 32'h00FF);
        send(8'd10, 8'd0, 3'd3, 4'd6);
        take("dz");
        check("dz_k", 32'(last_res), 32'hFFFF);
        check("dz_flag", 32'(last_dbz), 32'(1));
        send(8'd10, 8'd3, 3'd3, 4'd7);
        take("div");
        check("div_k", 32'(last_res), 32'd3);
        check("div_flag", 32'(last_dbz), 32'(0));

        // Backpressure: one in flight plus four queued, then full.
        r_ready = 1'b0;
        for (int i = 0; i < 5; i++)
            send(8'(i * 37), 8'(i + 1), 3'(i), 4'(i));
        c_a = 8'd77; c_b = 8'd11; c_op = 3'd6; c_tag = 4'd5;
        c_valid = 1'b1;
        check("bp_full", 32'(c_ready), 32'(0));
        tick();
        check("bp_full2", 32'(c_ready), 32'(0));
        got = 0; last = 0; cyc = 0;
        r_ready = 1'b1;
        while (got < 6 && cyc < 100) begin
            acc = c_valid && c_ready;
            if (r_valid) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 21'h1FFFFF;
                check("bp_tag", 32'(r_tag), 32'(got));
                check("bp_res", 32'(r_res), 32'(e[15:0]));
                if (got > 0) check("bp_gap", 32'(cyc - last), 32'd2);
                last = cyc;
                got++;
                exp_ops++;
            end
            tick();
            cyc++;
            if (acc) begin
                c_valid = 1'b0;
                exp_q.push_back(ref_rsp(8'd77, 8'd11, 3'd6, 4'd5));
            end
        end
        r_ready = 1'b0;
        check("bp_count", 32'(got), 32'd6);
        check("bp_busy", 32'(busy), 32'(0));
        check("bp_ops", 32'(ops), 32'(exp_ops));
        check("bp_ready", 32'(c_ready), 32'(1));

        // Randomized traffic with random response backpressure.
        sent = 0; recvd = 0; cyc = 0;
        while (recvd < 40 && cyc < 3000) begin
            if (!c_valid && sent < 40 && $urandom_range(0, 1) == 1) begin
                c_a = 8'($urandom);
                c_b = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
                c_op = 3'($urandom);
                c_tag = 4'($urandom);
                c_valid = 1'b1;
            end
            r_ready = ($urandom_range(0, 3) != 0);
            acc = c_valid && c_ready;
            hs = r_valid && r_ready;
            if (hs) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 21'h1FFFFF;
                check("rnd_res", 32'(r_res), 32'(e[15:0]));
                check("rnd_dbz", 32'(r_dbz), 32'(e[16]));
                check("rnd_tag", 32'(r_tag), 32'(e[20:17]));
                recvd++;
                exp_ops++;
            end
            if (acc) begin
                exp_q.push_back(ref_rsp(c_a, c_b, c_op, c_tag));
                sent++;
            end
            tick();
            cyc++;
            if (acc) c_valid = 1'b0;
        end
        r_ready = 1'b0;
        check("rnd_count", 32'(recvd), 32'd40);
        check("rnd_ops", 32'(ops), 32'(exp_ops));

        // Longer settle time: latency and alu_req stability.
        c3_a = 8'd50; c3_b = 8'd6; c3_op = 3'd2; c3_tag = 4'd9;
        req3 = {8'd50, 8'd6, 3'd2};
        c3_valid = 1'b1;
        tick();
        c3_valid = 1'b0;
        check("s3_lat0", 32'(r3_valid), 32'(0));
        for (int k = 1; k < 4; k++) begin
            tick();
            check("s3_wait", 32'(r3_valid), 32'(0));
            check("s3_req", 32'(a_req3), 32'(req3));
        end
        tick();
        check("s3_valid", 32'(r3_valid), 32'(1));
        check("s3_res", 32'(r3_res), 32'd300);
        check("s3_tag", 32'(r3_tag), 32'd9);
        check("s3_req_h", 32'(a_req3), 32'(req3));
        r3_ready = 1'b1;
        tick();
        r3_ready = 1'b0;
        check("s3_ops", 32'(ops3), 32'd1);
        check("s3_req_i", 32'(a_req3), 32'(req3));

        // Reset while a command is in WAIT.
        c3_a = 8'd1; c3_b = 8'd2; c3_op = 3'd0; c3_tag = 4'd3;
        c3_valid = 1'b1;
        tick();
        c3_valid = 1'b0;
        tick();
        check("ab_busy", 32'(busy3), 32'(1));
        rst = 1'b1;
        #1;
        check("ab_valid", 32'(r3_valid), 32'(0));
        check("ab_req", 32'(a_req3), 32'(0));
        check("ab_busy0", 32'(busy3), 32'(0));
        check("ab_ops", 32'(ops3), 32'(0));
        tick();
        rst = 1'b0;
        #1;
        check("ab_ready", 32'(c3_ready), 32'(1));
        highs = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (r3_valid) highs++;
        end
        check("ab_norsp", 32'(highs), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
